// File: rtl/add7_pkg.sv
// Shared types and defaults for the add7 sequential summing responder.
// Used by add7_opmux and add7_seq.
package add7_pkg;

    localparam int unsigned W_N_DFLT = 10;
    localparam int unsigned W_W_DFLT = 13;
    localparam int unsigned CNT_W    = 3;

    typedef logic [CNT_W-1:0] cnt_t;

    // Index of the last operand (g); its add completes the run.
    localparam cnt_t LAST_IDX = cnt_t'(6);
    localparam cnt_t FIRST_IDX = cnt_t'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add7_opmux.sv
// Operand selector: picks the latched operand addressed by cnt and
// zero-extends it to the accumulator width.
module add7_opmux
    import add7_pkg::*;
#(
    parameter int unsigned W_N = W_N_DFLT,
    parameter int unsigned W_W = W_W_DFLT
) (
    input  logic [W_N-1:0] op_b,
    input  logic [W_N-1:0] op_c,
    input  logic [W_N-1:0] op_d,
    input  logic [W_W-1:0] op_e,
    input  logic [W_N-1:0] op_f,
    input  logic [W_W-1:0] op_g,
    input  cnt_t           cnt,
    output logic [W_W-1:0] operand_c
);

    always_comb begin
        operand_c = '0;
        case (cnt)
            3'd1:    operand_c = W_W'(op_b);
            3'd2:    operand_c = W_W'(op_c);
            3'd3:    operand_c = W_W'(op_d);
            3'd4:    operand_c = op_e;
            3'd5:    operand_c = W_W'(op_f);
            3'd6:    operand_c = op_g;
            default: operand_c = '0;
        endcase
    end

endmodule

// File: rtl/add7_seq.sv
// Resource-shared seven-operand adder: one add per cycle under FSM control,
// start/done pulse handshake. ADD7_SEQ_OVERFLOW_EN adds the ovf output.
module add7_seq
    import add7_pkg::*;
#(
    parameter int unsigned W_N = W_N_DFLT,
    parameter int unsigned W_W = W_W_DFLT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           r_enable,
    input  logic           controlArr,
    input  logic [W_N-1:0] init_a,
    input  logic [W_N-1:0] init_b,
    input  logic [W_N-1:0] init_c,
    input  logic [W_N-1:0] init_d,
    input  logic [W_W-1:0] init_e,
    input  logic [W_N-1:0] init_f,
    input  logic [W_W-1:0] init_g,
    output logic           w_enable,
    output logic [W_W-1:0] result
`ifdef ADD7_SEQ_OVERFLOW_EN
    ,
    output logic           ovf
`endif
);

    state_t         state, state_n;
    cnt_t           cnt, cnt_n;
    logic [W_W-1:0] acc, acc_n;
    logic [W_W-1:0] result_n;
    logic           w_enable_n;
    logic           load_c;

    logic [W_N-1:0] op_b, op_c, op_d, op_f;
    logic [W_W-1:0] op_e, op_g;
    logic [W_W-1:0] operand_c;
    logic [W_W-1:0] sum_c;

    add7_opmux #(
        .W_N (W_N),
        .W_W (W_W)
    ) u_opmux (
        .op_b      (op_b),
        .op_c      (op_c),
        .op_d      (op_d),
        .op_e      (op_e),
        .op_f      (op_f),
        .op_g      (op_g),
        .cnt       (cnt),
        .operand_c (operand_c)
    );

`ifdef ADD7_SEQ_OVERFLOW_EN
    logic [W_W:0]   sum_wide_c;
    logic           carry_c;
    logic           ovf_run, ovf_run_n;
    logic           ovf_n;

    assign sum_wide_c = {1'b0, acc} + {1'b0, operand_c};
    assign sum_c      = sum_wide_c[W_W-1:0];
    assign carry_c    = sum_wide_c[W_W];
`else
    assign sum_c = acc + operand_c;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        acc_n      = acc;
        result_n   = result;
        w_enable_n = 1'b0;
        load_c     = 1'b0;
`ifdef ADD7_SEQ_OVERFLOW_EN
        ovf_run_n  = ovf_run;
        ovf_n      = ovf;
`endif
        case (state)
            IDLE: begin
                if (r_enable) begin
                    load_c  = 1'b1;
                    acc_n   = W_W'(init_a);
                    cnt_n   = FIRST_IDX;
                    state_n = RUN;
`ifdef ADD7_SEQ_OVERFLOW_EN
                    ovf_run_n = 1'b0;
`endif
                end
            end
            RUN: begin
                if (!controlArr) begin
                    acc_n = sum_c;
                    cnt_n = cnt + cnt_t'(1);
`ifdef ADD7_SEQ_OVERFLOW_EN
                    ovf_run_n = ovf_run | carry_c;
`endif
                    if (cnt == LAST_IDX) begin
                        result_n   = sum_c;
                        w_enable_n = 1'b1;
                        state_n    = DONE;
`ifdef ADD7_SEQ_OVERFLOW_EN
                        ovf_n = ovf_run | carry_c;
`endif
                    end
                end
            end
            DONE: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Accumulator, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            result   <= '0;
            w_enable <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            acc      <= acc_n;
            result   <= result_n;
            w_enable <= w_enable_n;
        end
    end

`ifdef ADD7_SEQ_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_run <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            ovf_run <= ovf_run_n;
            ovf     <= ovf_n;
        end
    end
`endif

    // Operands captured once at start so input changes during a run are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            op_b <= '0;
            op_c <= '0;
            op_d <= '0;
            op_e <= '0;
            op_f <= '0;
            op_g <= '0;
        end else if (load_c) begin
            op_b <= init_b;
            op_c <= init_c;
            op_d <= init_d;
            op_e <= init_e;
            op_f <= init_f;
            op_g <= init_g;
        end
    end

endmodule

// File: doc/add7_seq.md
Name: add7_seq

Overview:
- Synthesizable responder for the add7 start/done protocol: sums seven operands a..g and reports the 13-bit result.
- Used as a scheduled, resource-shared datapath: one adder, one operand per cycle, FSM-controlled.
- A one-cycle `r_enable` pulse starts it; it returns a one-cycle `w_enable` pulse with `result` valid.
- Drop-in counterpart of the bench driver: same port names, widths and handshake.

Parameters:
- W_N, 10, width of narrow operands a, b, c, d, f
- W_W, 13, width of wide operands e, g and of `result`/accumulator

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- r_enable  in  1  start pulse; sampled only in IDLE
- controlArr  in  1  stall; 1 freezes FSM, counter and accumulator
- init_a, init_b, init_c, init_d  in  W_N each  narrow operands
- init_e  in  W_W  wide operand
- init_f  in  W_N  narrow operand
- init_g  in  W_W  wide operand
- w_enable  out  1  done pulse, one cycle, registered
- result  out  W_W  sum mod 2^W_W; held until next completion

Behaviour:
- Reset (sync, `rst`=1 at posedge): state=IDLE, cnt=0, acc=0, `result`=0, `w_enable`=0. Reset overrides everything, including mid-run; a run in progress is abandoned with no `w_enable`.
- States: IDLE, RUN, DONE.
- IDLE:
  - When `r_enable`=1 at a posedge: latch all seven operands into registers, acc<=zero-extended a, cnt<=1, go RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each non-stalled posedge: acc<=acc+op[cnt]. Operand order by cnt: 1=b, 2=c, 3=d, 4=e, 5=f, 6=g. Narrow operands are zero-extended to W_W.
  - Addition is W_W bits and wraps modulo 2^W_W.
  - cnt<=cnt+1. When cnt==6: `result`<=acc+g, `w_enable`<=1, go DONE.
- DONE: `w_enable`<=0, go IDLE. `w_enable` is therefore high for exactly one cycle.
- Latency: `w_enable` rises at the 6th non-stalled posedge after the edge that sampled `r_enable`.
- Throughput: one sum per 8 cycles, since a new start is accepted in IDLE only.
- `r_enable` in RUN or DONE is ignored, not queued. A level-high `r_enable` restarts on the first IDLE cycle.
- `controlArr`=1 in RUN: hold state, cnt and acc.
  - In IDLE, stall does not block the start.
  - In DONE, stall does not extend `w_enable`.
- Operands are latched at start; input changes during RUN have no effect.
- `result` changes only at completion or reset.

Optional Feature:
- Macro ADD7_SEQ_OVERFLOW_EN.
- Defined: extra output port `ovf` (1 bit).
  - Set when any add in the run carries out of W_W bits.
  - Cleared at run start and by reset.
  - Registered to become valid together with `w_enable`; held with `result`.
- Undefined: port absent, no carry logic; `result` behaviour is identical.

Decomposition:
- Package add7_pkg:
  - `state_t` enum {IDLE, RUN, DONE}
  - W_N/W_W defaults as localparams
  - LAST_IDX=6
  - cnt type (3-bit)
- Sub-module add7_opmux: combinational selector. Takes the latched operand registers and cnt, returns the zero-extended W_W operand.
- FSM, accumulator and output registers stay in add7_seq.

Test Plan:
- Nominal: a..g=123,234,345,456,567,678,789; `r_enable` pulse from 25 to 50 ns, 20 ns clock.
  - Expect a single `w_enable` pulse 6 cycles after the sampling edge, `result`=3192.
  - `w_enable` low the next cycle; `result` stays 3192.
- Wrap: a..d,f=1023, e=g=8191.
  - Expect `result`=21497 mod 8192=5113.
  - With ADD7_SEQ_OVERFLOW_EN: `ovf`=1. With all inputs 1: `result`=7, `ovf`=0.
- Busy/back-to-back:
  - Second `r_enable` at cycle 3 of RUN: ignored, one `w_enable` only.
  - `r_enable` held high: completions 8 cycles apart, each `result`=3192.
- Stall: `controlArr`=1 for 4 cycles mid-RUN.
  - `w_enable` delayed by exactly 4 cycles, `result`=3192.
  - Operand changes during the stall do not alter the result.
- Reset mid-run: `rst` at cycle 3 of RUN.
  - Next cycle: `result`=0, `w_enable`=0, state IDLE, and no `w_enable` follows.
  - A new start then gives 3192.
- Reset state: after `rst`, with no start for 20 cycles, `w_enable` stays 0 and `result`=0.
